// File: rtl/la_bec_pkg.sv
// ----------------------------------------------------------------------------
// la_bec_pkg
// Shared constants for the logic-analyser host controller: command opcodes,
// controller state encoding, status codes and the chunk-count helper.
// ----------------------------------------------------------------------------
package la_bec_pkg;

    localparam logic [15:0] OPC_START   = 16'hAB30;  // IDLE -> LOAD
    localparam logic [15:0] OPC_WRITE   = 16'hAB31;  // write operand chunk
    localparam logic [15:0] OPC_RUN     = 16'hAB41;  // LOAD -> RUN
    localparam logic [15:0] OPC_READ    = 16'hAB50;  // read result chunk
    localparam logic [15:0] OPC_RELEASE = 16'hAB60;  // DONE/ERR -> IDLE
    localparam logic [15:0] OPC_ABORT   = 16'hABFF;  // any -> IDLE, clear all

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DONE = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } la_state_e;

    localparam logic [3:0] STS_NONE = 4'h0;
    localparam logic [3:0] STS_OK   = 4'h1;
    localparam logic [3:0] STS_TMO  = 4'hD;
    localparam logic [3:0] STS_NAK  = 4'hE;

    function automatic int calc_nch(input int op_w, input int chunk_w);
        return (op_w + chunk_w - 1) / chunk_w;
    endfunction

endpackage

// File: rtl/la_chunk_bank.sv
// ----------------------------------------------------------------------------
// la_chunk_bank
// One OP_W-bit register accessed as NCH chunks of CHUNK_W bits. The top chunk
// is truncated to OP_W on write and zero-extended on read.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_clr            synchronous clear (abort)
//   i_wr_en          write i_wr_data into chunk i_wr_chunk
//   i_ld_en          parallel load of i_ld_data (result capture)
//   i_shift_en       shift right by one, zero fill (key register)
//   i_rd_chunk       chunk selected onto o_rd_data
//   o_rd_data        selected chunk, combinational
//   o_q              full register value
// Priority: reset/clear > load > shift > chunk write.
// ----------------------------------------------------------------------------
module la_chunk_bank
    import la_bec_pkg::*;
#(
    parameter int OP_W    = 163,
    parameter int CHUNK_W = 64
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_wr_en,
    input  logic [7:0]         i_wr_chunk,
    input  logic [CHUNK_W-1:0] i_wr_data,
    input  logic               i_ld_en,
    input  logic [OP_W-1:0]    i_ld_data,
    input  logic               i_shift_en,
    input  logic [7:0]         i_rd_chunk,
    output logic [CHUNK_W-1:0] o_rd_data,
    output logic [OP_W-1:0]    o_q
);

    localparam int NCH   = calc_nch(OP_W, CHUNK_W);
    localparam int PAD_W = NCH * CHUNK_W;

    logic [OP_W-1:0]  r_q;
    logic [PAD_W-1:0] w_pad;
    logic [PAD_W-1:0] w_wr_pad;

    // Work on a zero-padded copy so every chunk, including the short top one,
    // is a full CHUNK_W slice; the padding is dropped again on write-back.
    always_comb begin
        w_pad     = PAD_W'(r_q);
        w_wr_pad  = w_pad;
        o_rd_data = '0;
        for (int c = 0; c < NCH; c++) begin
            if (i_wr_chunk == 8'(c)) begin
                w_wr_pad[c*CHUNK_W +: CHUNK_W] = i_wr_data;
            end
            if (i_rd_chunk == 8'(c)) begin
                o_rd_data = w_pad[c*CHUNK_W +: CHUNK_W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_q <= '0;
        end else if (i_ld_en) begin
            r_q <= i_ld_data;
        end else if (i_shift_en) begin
            r_q <= {1'b0, r_q[OP_W-1:1]};
        end else if (i_wr_en) begin
            r_q <= w_wr_pad[OP_W-1:0];
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/la_bec_host_ctrl.sv
// ----------------------------------------------------------------------------
// la_bec_host_ctrl
// Host-side controller driven over the logic-analyser port. A toggle on
// la_data_in[0] issues a command; the controller answers by toggling
// la_data_out[0] one cycle later with state, status and read data.
// Operands (last one is the key) are loaded chunk-wise, the core is run
// with the key shifted out LSB-first, and results are captured on done.
//
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   la_data_in           command word: [0] toggle, [31:16] opcode,
//                        [15:8] register index, [7:0] chunk, [CHUNK_W+31:32] data
//   la_oenb              commands accepted only while la_oenb[31:0] == 0
//   la_data_out          [0] ack, [127:124] state, [123:120] status,
//                        [119:112] chunk echo, [CHUNK_W+31:32] read data
//   core_enable          high only in RUN
//   core_ki              key[0]
//   core_next_key        shift key right by one while in RUN
//   core_done            capture results, RUN -> DONE
//   ops_flat             operand i at [i*OP_W +: OP_W]
//   res_flat             core results, captured on done
//
// Build option: define LA_HOST_TMO_EN to add a RUN watchdog that forces ERR
// (status 0xD) when a TMO_W-bit cycle counter reaches all-ones.
// ----------------------------------------------------------------------------
module la_bec_host_ctrl
    import la_bec_pkg::*;
#(
    parameter int OP_W    = 163,
    parameter int CHUNK_W = 64,
    parameter int NUM_OPS = 7,
    parameter int NUM_RES = 2,
    parameter int TMO_W   = 20
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [127:0]              la_data_in,
    input  logic [127:0]              la_oenb,
    output logic [127:0]              la_data_out,
    output logic                      core_enable,
    output logic                      core_ki,
    input  logic                      core_next_key,
    input  logic                      core_done,
    output logic [NUM_OPS*OP_W-1:0]   ops_flat,
    input  logic [NUM_RES*OP_W-1:0]   res_flat
);

    localparam int NCH     = calc_nch(OP_W, CHUNK_W);
    localparam int KEY_IDX = NUM_OPS - 1;

    la_state_e          r_state;
    logic               r_tgl_prev;
    logic               r_ack;
    logic [3:0]         r_status;
    logic [7:0]         r_echo;
    logic [CHUNK_W-1:0] r_rdata;
    logic               r_core_en;

    logic               w_accept;
    logic [15:0]        w_opc;
    logic [7:0]         w_idx;
    logic [7:0]         w_chk;
    logic [CHUNK_W-1:0] w_data;
    logic               w_chk_ok;
    logic               w_abort;
    logic               w_wr_ok;
    logic               w_rd_ok;
    logic               w_capture;
    logic               w_key_shift;
    logic [CHUNK_W-1:0] w_rd_data;
    logic [127:0]       w_status_word;

    logic [OP_W-1:0]    w_op_q [NUM_OPS];
    logic [CHUNK_W-1:0] w_op_rd_unused [NUM_OPS];
    logic [OP_W-1:0]    w_res_q_unused [NUM_RES];
    logic [CHUNK_W-1:0] w_res_rd [NUM_RES];

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    assign w_opc  = la_data_in[31:16];
    assign w_idx  = la_data_in[15:8];
    assign w_chk  = la_data_in[7:0];
    assign w_data = la_data_in[CHUNK_W+31:32];

    always_comb begin
        w_accept    = (la_data_in[0] != r_tgl_prev) && (la_oenb[31:0] == 32'h0);
        w_chk_ok    = (int'(w_chk) < NCH);
        w_abort     = w_accept && (w_opc == OPC_ABORT);
        w_wr_ok     = w_accept && (r_state == ST_LOAD) && (w_opc == OPC_WRITE)
                      && (int'(w_idx) < NUM_OPS) && w_chk_ok;
        w_rd_ok     = w_accept && (r_state == ST_DONE) && (w_opc == OPC_READ)
                      && (int'(w_idx) < NUM_RES) && w_chk_ok;
        // An abort in the same cycle as done discards the results.
        w_capture   = (r_state == ST_RUN) && core_done && !w_abort;
        w_key_shift = (r_state == ST_RUN) && core_next_key;
        w_rd_data   = '0;
        for (int r = 0; r < NUM_RES; r++) begin
            if (int'(w_idx) == r) begin
                w_rd_data = w_res_rd[r];
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand and result registers
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        la_chunk_bank #(
            .OP_W    (OP_W),
            .CHUNK_W (CHUNK_W)
        ) u_bank (
            .i_clk      (wb_clk_i),
            .i_rst      (wb_rst_i),
            .i_clr      (w_abort),
            .i_wr_en    (w_wr_ok && (w_idx == 8'(i))),
            .i_wr_chunk (w_chk),
            .i_wr_data  (w_data),
            .i_ld_en    (1'b0),
            .i_ld_data  ({OP_W{1'b0}}),
            .i_shift_en ((i == KEY_IDX) && w_key_shift),
            .i_rd_chunk (w_chk),
            .o_rd_data  (w_op_rd_unused[i]),
            .o_q        (w_op_q[i])
        );
        assign ops_flat[i*OP_W +: OP_W] = w_op_q[i];
    end

    for (genvar i = 0; i < NUM_RES; i++) begin : g_res
        la_chunk_bank #(
            .OP_W    (OP_W),
            .CHUNK_W (CHUNK_W)
        ) u_bank (
            .i_clk      (wb_clk_i),
            .i_rst      (wb_rst_i),
            .i_clr      (w_abort),
            .i_wr_en    (1'b0),
            .i_wr_chunk (w_chk),
            .i_wr_data  (w_data),
            .i_ld_en    (w_capture),
            .i_ld_data  (res_flat[i*OP_W +: OP_W]),
            .i_shift_en (1'b0),
            .i_rd_chunk (w_chk),
            .o_rd_data  (w_res_rd[i]),
            .o_q        (w_res_q_unused[i])
        );
    end

`ifdef LA_HOST_TMO_EN
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] w_tmo_next;
    assign w_tmo_next = r_tmo + TMO_W'(1);
`else
    logic [TMO_W-1:0] w_tmo_unused;
    assign w_tmo_unused = '0;
`endif

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_IDLE;
            // Track the current toggle so releasing reset is not a request.
            r_tgl_prev <= la_data_in[0];
            r_ack      <= 1'b0;
            r_status   <= STS_NONE;
            r_echo     <= 8'h00;
            r_rdata    <= '0;
            r_core_en  <= 1'b0;
`ifdef LA_HOST_TMO_EN
            r_tmo      <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_tgl_prev <= la_data_in[0];
                r_ack      <= ~r_ack;
                r_echo     <= w_chk;
                r_status   <= STS_NAK;
                case (w_opc)
                    OPC_ABORT: begin
                        r_state   <= ST_IDLE;
                        r_core_en <= 1'b0;
                        r_rdata   <= '0;
                        r_status  <= STS_OK;
                    end
                    OPC_START: begin
                        if (r_state == ST_IDLE) begin
                            r_state  <= ST_LOAD;
                            r_status <= STS_OK;
                        end
                    end
                    OPC_WRITE: begin
                        if (w_wr_ok) begin
                            r_status <= STS_OK;
                        end
                    end
                    OPC_RUN: begin
                        if (r_state == ST_LOAD) begin
                            r_state   <= ST_RUN;
                            r_core_en <= 1'b1;
                            r_status  <= STS_OK;
`ifdef LA_HOST_TMO_EN
                            r_tmo     <= '0;
`endif
                        end
                    end
                    OPC_READ: begin
                        if (w_rd_ok) begin
                            r_rdata  <= w_rd_data;
                            r_status <= STS_OK;
                        end
                    end
                    OPC_RELEASE: begin
                        if ((r_state == ST_DONE) || (r_state == ST_ERR)) begin
                            r_state  <= ST_IDLE;
                            r_status <= STS_OK;
                        end
                    end
                    default: ;
                endcase
            end

            // Core events come last so they override a NAKed request's
            // bookkeeping, but never an abort.
            if ((r_state == ST_RUN) && !w_abort) begin
                if (core_done) begin
                    r_state   <= ST_DONE;
                    r_core_en <= 1'b0;
                end
`ifdef LA_HOST_TMO_EN
                else if (w_tmo_next == '1) begin
                    r_state   <= ST_ERR;
                    r_core_en <= 1'b0;
                    r_status  <= STS_TMO;
                    r_tmo     <= w_tmo_next;
                end else begin
                    r_tmo <= w_tmo_next;
                end
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_status_word                = '0;
        w_status_word[0]             = r_ack;
        w_status_word[127:124]       = {1'b0, r_state};
        w_status_word[123:120]       = r_status;
        w_status_word[119:112]       = r_echo;
        w_status_word[CHUNK_W+31:32] = r_rdata;
    end

    assign la_data_out = w_status_word;
    assign core_enable = r_core_en;
    assign core_ki     = w_op_q[KEY_IDX][0];

    logic w_unused;
    assign w_unused = ^{la_oenb[127:32], la_data_in[127:CHUNK_W+32]};

endmodule

// File: tb/tb_la_bec_host_ctrl.sv
module tb_la_bec_host_ctrl;

    localparam int OP_W    = 163;
    localparam int CHUNK_W = 64;
    localparam int NUM_OPS = 7;
    localparam int NUM_RES = 2;

    localparam logic [15:0] C_START   = 16'hAB30;
    localparam logic [15:0] C_WRITE   = 16'hAB31;
    localparam logic [15:0] C_RUN     = 16'hAB41;
    localparam logic [15:0] C_READ    = 16'hAB50;
    localparam logic [15:0] C_RELEASE = 16'hAB60;
    localparam logic [15:0] C_ABORT   = 16'hABFF;

    logic                    wb_clk_i = 1'b0;
    logic                    wb_rst_i;
    logic [127:0]            la_data_in;
    logic [127:0]            la_oenb;
    logic [127:0]            la_data_out;
    logic                    core_enable;
    logic                    core_ki;
    logic                    core_next_key;
    logic                    core_done;
    logic [NUM_OPS*OP_W-1:0] ops_flat;
    logic [NUM_RES*OP_W-1:0] res_flat;

    la_bec_host_ctrl #(
        .OP_W    (OP_W),
        .CHUNK_W (CHUNK_W),
        .NUM_OPS (NUM_OPS),
        .NUM_RES (NUM_RES),
        .TMO_W   (4)
    ) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .la_data_in    (la_data_in),
        .la_oenb       (la_oenb),
        .la_data_out   (la_data_out),
        .core_enable   (core_enable),
        .core_ki       (core_ki),
        .core_next_key (core_next_key),
        .core_done     (core_done),
        .ops_flat      (ops_flat),
        .res_flat      (res_flat)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic tgl      = 1'b0;
    logic exp_ack  = 1'b0;

    typedef struct {
        logic [15:0] opc;
        logic [7:0]  idx;
        logic [7:0]  chk;
        logic [63:0] data;
        logic [2:0]  est;
        logic [3:0]  ests;
    } vec_t;

    vec_t load_tbl [12];

    logic [162:0] res0;
    logic [162:0] res1;
    logic         exp_ki [3];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One request: toggle bit 0 (which is also chunk bit 0), expect ack one
    // cycle later, then leave one idle cycle before the next request.
    task automatic send(input string name, input logic [15:0] opc, input logic [7:0] idx,
                        input logic [7:0] chk, input logic [63:0] data,
                        input logic [2:0] est, input logic [3:0] ests,
                        input logic dchk, input logic [63:0] edata);
        @(negedge wb_clk_i);
        tgl        = ~tgl;
        la_data_in = {32'h0, data, opc, idx, chk[7:1], tgl};
        @(negedge wb_clk_i);
        exp_ack = ~exp_ack;
        check({name, " ack"},    la_data_out[0],        exp_ack);
        check({name, " state"},  la_data_out[127:124],  {1'b0, est});
        check({name, " status"}, la_data_out[123:120],  ests);
        check({name, " echo"},   la_data_out[119:112],  {chk[7:1], tgl});
        if (dchk) check({name, " rdata"}, la_data_out[95:32], edata);
        @(negedge wb_clk_i);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // chunk bit 0 equals the toggle value each entry will carry
        load_tbl[0]  = '{C_START,   8'd0, 8'h01, 64'h0,                 3'd1, 4'h1};
        load_tbl[1]  = '{C_WRITE,   8'd0, 8'h00, 64'h1111111111111111,  3'd1, 4'h1};
        load_tbl[2]  = '{C_WRITE,   8'd0, 8'h01, 64'h2222222222222222,  3'd1, 4'h1};
        load_tbl[3]  = '{C_WRITE,   8'd0, 8'h02, 64'h7,                 3'd1, 4'h1};
        load_tbl[4]  = '{C_WRITE,   8'd0, 8'h03, 64'hDEAD,              3'd1, 4'hE};
        load_tbl[5]  = '{C_WRITE,   8'd7, 8'h00, 64'hBEEF,              3'd1, 4'hE};
        load_tbl[6]  = '{C_READ,    8'd0, 8'h01, 64'h0,                 3'd1, 4'hE};
        load_tbl[7]  = '{C_WRITE,   8'd1, 8'h02, 64'hFFFFFFFFFFFFFFFF,  3'd1, 4'h1};
        load_tbl[8]  = '{C_RELEASE, 8'd0, 8'h01, 64'h0,                 3'd1, 4'hE};
        load_tbl[9]  = '{C_WRITE,   8'd6, 8'h00, 64'hB,                 3'd1, 4'h1};
        load_tbl[10] = '{C_WRITE,   8'd0, 8'h05, 64'h5555,              3'd1, 4'hE};
        load_tbl[11] = '{C_RUN,     8'd0, 8'h00, 64'h0,                 3'd3, 4'h1};

        res0 = {35'h0, 64'hA5A5A5A5A5A5A5A5, 64'h0123456789ABCDEF};
        res1 = {35'h4ABCD1234, 64'h0, 64'hDEADBEEF01234567};
        exp_ki[0] = 1'b1;
        exp_ki[1] = 1'b0;
        exp_ki[2] = 1'b1;

        wb_rst_i      = 1'b1;
        la_data_in    = '0;
        la_oenb       = '0;
        core_next_key = 1'b0;
        core_done     = 1'b0;
        res_flat      = '0;
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        check("rst la_data_out", la_data_out, 128'h0);
        check("rst core_enable", core_enable, 1'b0);
        check("rst core_ki",     core_ki,     1'b0);
        check("rst ops_zero",    ops_flat == '0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            send($sformatf("vec%0d", i), load_tbl[i].opc, load_tbl[i].idx, load_tbl[i].chk,
                 load_tbl[i].data, load_tbl[i].est, load_tbl[i].ests, 1'b0, 64'h0);
        end

        check("op0 value", ops_flat[0 +: OP_W],
              {35'h7, 64'h2222222222222222, 64'h1111111111111111});
        check("op1 top truncated", ops_flat[OP_W +: OP_W], {35'h7FFFFFFFF, 128'h0});
        check("key value", ops_flat[6*OP_W +: OP_W], 163'hB);
        check("run core_enable", core_enable, 1'b1);
        check("run ki0", core_ki, 1'b1);

        // Requests in RUN are refused and leave the core alone
        send("run write nak", C_WRITE, 8'd0, 8'h01, 64'hFFFF, 3'd3, 4'hE, 1'b0, 64'h0);
        check("run nak core_enable", core_enable, 1'b1);
        check("run nak op0", ops_flat[0 +: OP_W],
              {35'h7, 64'h2222222222222222, 64'h1111111111111111});

        for (int k = 0; k < 3; k++) begin
            @(negedge wb_clk_i);
            core_next_key = 1'b1;
            @(negedge wb_clk_i);
            core_next_key = 1'b0;
            check($sformatf("ki step%0d", k + 1), core_ki, exp_ki[k]);
        end
        check("run core_enable after shifts", core_enable, 1'b1);

        res_flat = {res1, res0};
        @(negedge wb_clk_i);
        core_done = 1'b1;
        @(negedge wb_clk_i);
        core_done = 1'b0;
        res_flat  = '1;
        check("done state", la_data_out[127:124], 4'd2);
        check("done core_enable", core_enable, 1'b0);

        send("rd res1 c0", C_READ, 8'd1, 8'h00, 64'h0, 3'd2, 4'h1, 1'b1, 64'hDEADBEEF01234567);
        send("rd res0 c1", C_READ, 8'd0, 8'h01, 64'h0, 3'd2, 4'h1, 1'b1, 64'hA5A5A5A5A5A5A5A5);
        send("rd res1 c2", C_READ, 8'd1, 8'h02, 64'h0, 3'd2, 4'h1, 1'b1, 64'h00000004ABCD1234);
        send("rd idx2 nak", C_READ, 8'd2, 8'h01, 64'h0, 3'd2, 4'hE, 1'b1, 64'h00000004ABCD1234);
        send("rd chk4 nak", C_READ, 8'd0, 8'h04, 64'h0, 3'd2, 4'hE, 1'b1, 64'h00000004ABCD1234);

        // Request held off while la_oenb[31:0] is non-zero
        @(negedge wb_clk_i);
        la_oenb    = 128'h8000;
        tgl        = ~tgl;
        la_data_in = {32'h0, 64'h0, C_RELEASE, 8'd0, 7'd0, tgl};
        repeat (3) @(negedge wb_clk_i);
        check("oenb hold ack", la_data_out[0], exp_ack);
        check("oenb hold state", la_data_out[127:124], 4'd2);
        la_oenb = '0;
        @(negedge wb_clk_i);
        exp_ack = ~exp_ack;
        check("oenb release ack", la_data_out[0], exp_ack);
        check("oenb release state", la_data_out[127:124], 4'd0);
        check("oenb release status", la_data_out[123:120], 4'h1);
        @(negedge wb_clk_i);

        send("idle write nak", C_WRITE, 8'd0, 8'h00, 64'h1, 3'd0, 4'hE, 1'b0, 64'h0);
        send("start2", C_START, 8'd0, 8'h01, 64'h0, 3'd1, 4'h1, 1'b0, 64'h0);
        send("run2",   C_RUN,   8'd0, 8'h00, 64'h0, 3'd3, 4'h1, 1'b0, 64'h0);

        // Abort coinciding with done: abort wins, nothing captured
        @(negedge wb_clk_i);
        tgl        = ~tgl;
        la_data_in = {32'h0, 64'h0, C_ABORT, 8'd0, 7'd0, tgl};
        res_flat   = {res0, res1};
        core_done  = 1'b1;
        @(negedge wb_clk_i);
        core_done = 1'b0;
        exp_ack   = ~exp_ack;
        check("abort+done ack", la_data_out[0], exp_ack);
        check("abort+done state", la_data_out[127:124], 4'd0);
        check("abort+done status", la_data_out[123:120], 4'h1);
        check("abort+done core_enable", core_enable, 1'b0);
        check("abort ops cleared", ops_flat == '0, 1'b1);
        check("abort core_ki", core_ki, 1'b0);
        @(negedge wb_clk_i);

        // Reset while running
        send("start3", C_START, 8'd0, 8'h00, 64'h0, 3'd1, 4'h1, 1'b0, 64'h0);
        send("run3",   C_RUN,   8'd0, 8'h01, 64'h0, 3'd3, 4'h1, 1'b0, 64'h0);
        check("run3 core_enable", core_enable, 1'b1);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        check("rst in run core_enable", core_enable, 1'b0);
        check("rst in run la_data_out", la_data_out, 128'h0);
        wb_rst_i = 1'b0;
        exp_ack  = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        check("post rst no spurious", la_data_out, 128'h0);
        send("start4", C_START, 8'd0, 8'h00, 64'h0, 3'd1, 4'h1, 1'b0, 64'h0);

`ifdef LA_HOST_TMO_EN
        send("run tmo", C_RUN, 8'd0, 8'h01, 64'h0, 3'd3, 4'h1, 1'b0, 64'h0);
        repeat (13) @(negedge wb_clk_i);
        check("tmo still run", la_data_out[127:124], 4'd3);
        @(negedge wb_clk_i);
        check("tmo err state", la_data_out[127:124], 4'd4);
        check("tmo err status", la_data_out[123:120], 4'hD);
        check("tmo core_enable", core_enable, 1'b0);
        send("tmo abort", C_ABORT, 8'd0, 8'h00, 64'h0, 3'd0, 4'h1, 1'b0, 64'h0);
        check("tmo abort ops", ops_flat == '0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
